sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single SRAM controller port (Cs pulse / Ready level handshake, 22-bit word address, 32-bit data) between three requesters: boot loader (m0), CPU data port (m1) and CPU instruction port (m2).
- Sits between the flash-to-SRAM boot loader, the CPU memory stage and the SRAM controller.
- Sequences each access through the controller's Cs/Ready protocol and returns a one-cycle done pulse with read data to the winning requester.

Parameters:
- AW, 22, SRAM word-address width.
- DW, 32, SRAM data width.
- TIMEOUT, 255, cycles allowed in WAIT_RDY before the access is aborted and flagged.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- bootBusy  in  1  high while boot copy in progress; blocks m1/m2 grants
- m0Req, m1Req, m2Req  in  1 each  level request, held until matching done
- m0Addr, m1Addr, m2Addr  in  AW each  word address
- m0Wdata, m1Wdata  in  DW each  write data (m2 is read-only)
- m0We, m1We  in  1 each  1=write, 0=read
- m0Done, m1Done, m2Done  out  1 each  one-cycle completion pulse
- rdata  out  DW  read data, valid in the cycle of the mNDone pulse
- sramReady  in  1  controller idle/complete
- sramCs  out  1  one-cycle access strobe
- sramAddr  out  AW  access address
- sramData  out  DW  write data
- sramWe  out  1  write enable
- timeoutErr  out  1  sticky error flag
- sramRdata  in  DW  controller read data

Behaviour:
- Reset: all outputs 0; state IDLE; rrLast=m2 (so m1 wins the first tie); timeout counter 0.
- States:
  - IDLE: if sramReady, pick a winner, latch its addr/wdata/we into the sramAddr/sramData/sramWe registers and the grant index; go to ISSUE.
  - ISSUE: sramCs=1 for exactly this cycle; go to HOLD.
  - HOLD: one dead cycle, because Ready drops one cycle after Cs; go to WAIT_RDY.
  - WAIT_RDY: count cycles; when sramReady=1, capture sramRdata into rdata and go to DONE. If the count reaches TIMEOUT, set timeoutErr, rdata=0, go to DONE.
  - DONE: pulse the granted mNDone; go to IDLE.
- Priority:
  - m0 is absolute.
  - While bootBusy=1, only m0 can be granted.
  - Otherwise m1 and m2 are round-robin. rrLast updates in DONE. If only one requester is active, it wins regardless of rrLast.
- Minimum access: 5 cycles from IDLE with request to the done pulse (IDLE, ISSUE, HOLD, WAIT_RDY≥1, DONE). Back-to-back grants are allowed: IDLE re-arbitrates on the cycle after DONE.
- The grant is latched. Requester inputs changing after IDLE do not affect the access in flight. Deasserting mNReq mid-access still produces mNDone.
- A requester whose Req is still high in the cycle after its done is treated as a new request.
- m2 always issues a read: sramWe=0, sramData is don't-care and driven 0.
- sramAddr/sramData/sramWe hold their value from IDLE until the next grant.
- bootBusy rising mid-CPU-access: the current access completes; subsequent grants are m0 only.
- sramReady low in IDLE: no grant, wait.
- timeoutErr is cleared only by rst.
- Timeout counter: 8 bits wide minimum, sized to hold TIMEOUT, no wrap. It resets in HOLD.
- Reset mid-access: immediate return to IDLE. No done pulse. sramCs=0 asynchronously.

Decomposition:
- Shared package holds:
  - state encodings IDLE=0, ISSUE=1, HOLD=2, WAIT_RDY=3, DONE=4 (3-bit);
  - grant indices M0=0, M1=1, M2=2;
  - AW/DW defaults.
- One natural sub-module: sram_rr_pick, a combinational priority / round-robin picker taking reqs, bootBusy and rrLast and returning a valid flag and a 2-bit index. The FSM stays in sram_arbiter.

Test Plan:
- Single m1 write: addr 0x000010, data 0xDEADBEEF, model Ready low for 3 cycles → one sramCs pulse with sramAddr=0x000010, sramWe=1; m1Done 7 cycles after Req.
- m1 and m2 requesting continuously, bootBusy=0, reads → grants alternate m1,m2,m1,m2; each rdata matches the model value for that address.
- bootBusy=1 with m0, m1, m2 all requesting → only m0 granted across 4 accesses; after bootBusy=0, m1 is granted next.
- Model never raises Ready after Cs, TIMEOUT=255 → timeoutErr=1 and rdata=0 with the done pulse at cycle 255 of WAIT_RDY; next access proceeds normally and timeoutErr stays 1.
- rst asserted during WAIT_RDY → all outputs 0 immediately, no done pulse; the pending request is re-granted after rst falls.
- m2 read with m2Addr=0x3FFFFF (maximum address) → sramAddr=0x3FFFFF, sramWe=0, sramData=0.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM port arbiter and its requester picker.
package sram_arbiter_pkg;

  localparam int AW_DEF = 22;
  localparam int DW_DEF = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    HOLD     = 3'd2,
    WAIT_RDY = 3'd3,
    DONE     = 3'd4
  } arbState_t;

  localparam logic [1:0] M0 = 2'd0;
  localparam logic [1:0] M1 = 2'd1;
  localparam logic [1:0] M2 = 2'd2;

endpackage

// File: rtl/sram_rr_pick.sv
// Requester picker: boot loader (m0) is absolute, CPU ports round-robin
// and are locked out entirely while the boot copy runs.
module sram_rr_pick
  import sram_arbiter_pkg::*;
(
  input  logic [2:0] reqs,
  input  logic       bootBusy,
  input  logic [1:0] rrLast,
  output logic       valid,
  output logic [1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = M0;
    if (reqs[0]) begin
      valid = 1'b1;
      idx   = M0;
    end else if (!bootBusy) begin
      if (reqs[1] && reqs[2]) begin
        valid = 1'b1;
        idx   = (rrLast == M1) ? M2 : M1;
      end else if (reqs[1]) begin
        valid = 1'b1;
        idx   = M1;
      end else if (reqs[2]) begin
        valid = 1'b1;
        idx   = M2;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller port between the boot loader and the CPU
// data/instruction ports, sequencing each access through Cs/Ready.
//
// state    | meaning
// IDLE     | wait for controller ready and a grantable request, latch it
// ISSUE    | sramCs high for this single cycle
// HOLD     | dead cycle while the controller drops Ready
// WAIT_RDY | wait for Ready, abort after TIMEOUT cycles
// DONE     | done pulse to the granted requester
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bootBusy,
  input  logic          m0Req,
  input  logic          m1Req,
  input  logic          m2Req,
  input  logic [AW-1:0] m0Addr,
  input  logic [AW-1:0] m1Addr,
  input  logic [AW-1:0] m2Addr,
  input  logic [DW-1:0] m0Wdata,
  input  logic [DW-1:0] m1Wdata,
  input  logic          m0We,
  input  logic          m1We,
  output logic          m0Done,
  output logic          m1Done,
  output logic          m2Done,
  output logic [DW-1:0] rdata,
  input  logic          sramReady,
  output logic          sramCs,
  output logic [AW-1:0] sramAddr,
  output logic [DW-1:0] sramData,
  output logic          sramWe,
  output logic          timeoutErr,
  input  logic [DW-1:0] sramRdata
);

  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  // Last WAIT_RDY cycle is the TIMEOUT-th one, counter starts at 0
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  arbState_t     state;
  logic [1:0]    grant;
  logic [1:0]    rrLast;
  logic [CW-1:0] toCnt;
  logic          pickValid;
  logic [1:0]    pickIdx;

  sram_rr_pick uPick (
    .reqs     ({m2Req, m1Req, m0Req}),
    .bootBusy (bootBusy),
    .rrLast   (rrLast),
    .valid    (pickValid),
    .idx      (pickIdx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= M0;
      rrLast     <= M2;
      toCnt      <= '0;
      sramCs     <= 1'b0;
      sramAddr   <= '0;
      sramData   <= '0;
      sramWe     <= 1'b0;
      m0Done     <= 1'b0;
      m1Done     <= 1'b0;
      m2Done     <= 1'b0;
      rdata      <= '0;
      timeoutErr <= 1'b0;
    end else begin
      sramCs <= 1'b0;
      m0Done <= 1'b0;
      m1Done <= 1'b0;
      m2Done <= 1'b0;
      case (state)
        IDLE: begin
          if (sramReady && pickValid) begin
            grant  <= pickIdx;
            sramCs <= 1'b1;
            state  <= ISSUE;
            case (pickIdx)
              M0: begin
                sramAddr <= m0Addr;
                sramData <= m0Wdata;
                sramWe   <= m0We;
              end
              M1: begin
                sramAddr <= m1Addr;
                sramData <= m1Wdata;
                sramWe   <= m1We;
              end
              default: begin
                sramAddr <= m2Addr;
                sramData <= '0;
                sramWe   <= 1'b0;
              end
            endcase
          end
        end
        ISSUE: state <= HOLD;
        HOLD: begin
          toCnt <= '0;
          state <= WAIT_RDY;
        end
        WAIT_RDY: begin
          // Ready wins over timeout if both land on the same cycle
          if (sramReady || (toCnt == TO_LAST)) begin
            rdata      <= sramReady ? sramRdata : '0;
            timeoutErr <= timeoutErr | ~sramReady;
            m0Done     <= (grant == M0);
            m1Done     <= (grant == M1);
            m2Done     <= (grant == M2);
            state      <= DONE;
          end else begin
            toCnt <= toCnt + CW'(1);
          end
        end
        DONE: begin
          rrLast <= grant;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised bench for sram_arbiter: an SRAM controller emulator plus a
// transaction-timeline reference model compared against the DUT every cycle.
module tb_sram_arbiter;

  localparam int AW = 22;
  localparam int DW = 32;
  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          bootBusy;
  logic          m0Req, m1Req, m2Req;
  logic [AW-1:0] m0Addr, m1Addr, m2Addr;
  logic [DW-1:0] m0Wdata, m1Wdata;
  logic          m0We, m1We;
  logic          m0Done, m1Done, m2Done;
  logic [DW-1:0] rdata;
  logic          sramReady;
  logic          sramCs;
  logic [AW-1:0] sramAddr;
  logic [DW-1:0] sramData;
  logic          sramWe;
  logic          timeoutErr;
  logic [DW-1:0] sramRdata;

  sram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bootBusy(bootBusy),
    .m0Req(m0Req), .m1Req(m1Req), .m2Req(m2Req),
    .m0Addr(m0Addr), .m1Addr(m1Addr), .m2Addr(m2Addr),
    .m0Wdata(m0Wdata), .m1Wdata(m1Wdata), .m0We(m0We), .m1We(m1We),
    .m0Done(m0Done), .m1Done(m1Done), .m2Done(m2Done), .rdata(rdata),
    .sramReady(sramReady), .sramCs(sramCs), .sramAddr(sramAddr),
    .sramData(sramData), .sramWe(sramWe), .timeoutErr(timeoutErr),
    .sramRdata(sramRdata)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;

  // controller emulator
  int            emuLat = 3;
  int            busyLeft = 0;
  bit            csSeen = 0;
  bit            stallEn = 0;
  logic [AW-1:0] emuAddr = '0;

  // observations of the DUT used for stimulus and pins
  logic [2:0]    obsDone = '0;
  logic [DW-1:0] obsRdata = '0;
  int            csCount = 0;
  logic [AW-1:0] csAddr = '0;
  logic [DW-1:0] csData = '0;
  logic          csWe = 0;
  int            doneLog[$];

  // reference model
  bit            mBusy = 0, mInDone = 0;
  int            mAge = 0, mWin = 0, rrLast = 2;
  logic [AW-1:0] eAddr = '0;
  logic [DW-1:0] eData = '0;
  logic          eWe = 0, eErr = 0;
  logic [DW-1:0] eRdata = '0;

  function automatic logic [31:0] memFn(logic [21:0] a);
    return {a[9:0], a} ^ 32'hA5C3_0F96;
  endfunction

  function automatic int pickWinner(logic r0, logic r1, logic r2, logic bb, int last);
    if (r0) return 0;
    if (bb) return -1;
    if (r1 && r2) return (last == 1) ? 2 : 1;  // the CPU port that did not go last
    if (r1) return 1;
    if (r2) return 2;
    return -1;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic modelCycle();
    logic [2:0] expDone;
    int w;
    cyc++;
    if (rst) begin
      mBusy = 0; mInDone = 0; rrLast = 2;
      eAddr = '0; eData = '0; eWe = 0; eErr = 0;
      chk("reset_ctrl", {sramCs, m0Done, m1Done, m2Done, sramWe, timeoutErr}, '0);
      chk("reset_addr", sramAddr, '0);
      chk("reset_data", sramData, '0);
      chk("reset_rdata", rdata, '0);
      return;
    end
    expDone = mInDone ? (3'b001 << mWin) : 3'b000;
    chk("sramCs", sramCs, mBusy && !mInDone && mAge == 1);
    chk("done", {m2Done, m1Done, m0Done}, expDone);
    chk("timeoutErr", timeoutErr, eErr);
    chk("sramAddr", sramAddr, eAddr);
    chk("sramData", sramData, eData);
    chk("sramWe", sramWe, eWe);
    if (mInDone) chk("rdata", rdata, eRdata);

    if (mInDone) begin
      mInDone = 0; mBusy = 0; rrLast = mWin;
    end else if (mBusy) begin
      // access waits from its third cycle after the grant, for TIMEOUT cycles
      if (mAge >= 3) begin
        if (sramReady) begin
          mInDone = 1; eRdata = memFn(eAddr);
        end else if (mAge == 2 + TIMEOUT) begin
          mInDone = 1; eRdata = '0; eErr = 1;
        end
      end
      mAge++;
    end else begin
      w = pickWinner(m0Req, m1Req, m2Req, bootBusy, rrLast);
      if (sramReady && w >= 0) begin
        mBusy = 1; mAge = 1; mWin = w;
        case (w)
          0: begin eAddr = m0Addr; eData = m0Wdata; eWe = m0We; end
          1: begin eAddr = m1Addr; eData = m1Wdata; eWe = m1We; end
          default: begin eAddr = m2Addr; eData = '0; eWe = 0; end
        endcase
      end
    end
  endtask

  task automatic emuStep();
    if (csSeen) busyLeft = emuLat;
    sramReady = (busyLeft == 0) && !(stallEn && $urandom_range(0, 7) == 0);
    if (busyLeft > 0) busyLeft--;
    sramRdata = sramReady ? memFn(emuAddr) : $urandom();
  endtask

  task automatic tick();
    @(negedge clk);
    modelCycle();
    csSeen = sramCs;
    if (sramCs) begin
      csCount++; emuAddr = sramAddr;
      csAddr = sramAddr; csData = sramData; csWe = sramWe;
    end
    obsDone = {m2Done, m1Done, m0Done};
    if (obsDone != 0) begin
      obsRdata = rdata;
      for (int i = 0; i < 3; i++) if (obsDone[i]) doneLog.push_back(i);
    end
    @(posedge clk);
    #1;
    emuStep();
  endtask

  task automatic waitDone(int idx, int budget, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!obsDone[idx] && waited < budget);
    chk($sformatf("wait_m%0dDone", idx), obsDone[idx], 1'b1);
  endtask

  task automatic waitAny(int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (obsDone == 0 && n < budget);
    chk("wait_anyDone", obsDone != 0, 1'b1);
  endtask

  task automatic newM0();
    m0Addr = AW'($urandom()); m0Wdata = $urandom(); m0We = 1'($urandom_range(0, 1));
  endtask
  task automatic newM1();
    m1Addr = AW'($urandom()); m1Wdata = $urandom(); m1We = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int w, c0, n;
    logic [AW-1:0] a;
    rst = 1; bootBusy = 0;
    m0Req = 0; m1Req = 0; m2Req = 0;
    m0Addr = '0; m1Addr = '0; m2Addr = '0;
    m0Wdata = '0; m1Wdata = '0; m0We = 0; m1We = 0;
    sramReady = 1; sramRdata = '0;
    repeat (3) tick();
    rst = 0;
    tick();

    // single m1 write, Ready low for 3 cycles after Cs
    c0 = csCount;
    m1Req = 1; m1Addr = 22'h000010; m1Wdata = 32'hDEADBEEF; m1We = 1; emuLat = 3;
    waitDone(1, 20, w);
    m1Req = 0;
    chk("m1_write_latency", w, 7);
    chk("m1_write_cs_count", csCount - c0, 1);
    chk("m1_write_addr", csAddr, 22'h000010);
    chk("m1_write_we", csWe, 1'b1);
    chk("m1_write_data", csData, 32'hDEADBEEF);

    // m1 and m2 continuous reads: m1 went last, so m2 leads the alternation
    doneLog.delete();
    m1Req = 1; m1We = 0; m1Addr = AW'($urandom()); m2Req = 1; m2Addr = AW'($urandom());
    for (int k = 0; k < 6; k++) begin
      emuLat = $urandom_range(1, 5);
      waitAny(40);
      if (obsDone[1]) m1Addr = AW'($urandom());
      if (obsDone[2]) m2Addr = AW'($urandom());
    end
    chk("rr_count", doneLog.size(), 6);
    for (int k = 0; k < 6 && k < doneLog.size(); k++)
      chk($sformatf("rr_grant%0d", k), doneLog[k], (k % 2 == 0) ? 2 : 1);

    // boot copy in progress: only m0 until bootBusy drops, then m1
    doneLog.delete();
    bootBusy = 1; m0Req = 1; newM0();
    for (int k = 0; k < 4; k++) begin
      waitAny(40);
      if (obsDone[0]) newM0();
    end
    m0Req = 0; bootBusy = 0;
    waitAny(40);
    chk("boot_count", doneLog.size(), 5);
    for (int k = 0; k < 5 && k < doneLog.size(); k++)
      chk($sformatf("boot_grant%0d", k), doneLog[k], (k < 4) ? 0 : 1);

    // controller never answers: abort after TIMEOUT WAIT_RDY cycles
    m2Req = 0; m1Req = 1; m1We = 0; m1Addr = AW'($urandom()); emuLat = 400;
    waitDone(1, 300, w);
    m1Req = 0;
    chk("timeout_latency", w, 259);
    chk("timeout_rdata", obsRdata, '0);
    chk("timeout_err", timeoutErr, 1'b1);
    emuLat = 2; a = AW'($urandom()); m2Req = 1; m2Addr = a;
    waitDone(2, 300, w);
    chk("post_timeout_rdata", obsRdata, memFn(a));
    chk("post_timeout_err_sticky", timeoutErr, 1'b1);

    // reset in the middle of WAIT_RDY
    emuLat = 30; m2Addr = AW'($urandom()); a = m2Addr;
    repeat (5) tick();
    rst = 1;
    #1;
    chk("async_rst_ctrl", {sramCs, m0Done, m1Done, m2Done, sramWe, timeoutErr}, '0);
    chk("async_rst_addr", sramAddr, '0);
    chk("async_rst_rdata", rdata, '0);
    repeat (2) tick();
    rst = 0;
    waitDone(2, 200, w);
    chk("rst_regrant_rdata", obsRdata, memFn(a));

    // m2 read at the top address
    emuLat = 1; m2Addr = 22'h3FFFFF;
    waitDone(2, 20, w);
    m2Req = 0;
    chk("max_addr", csAddr, 22'h3FFFFF);
    chk("max_addr_we", csWe, 1'b0);
    chk("max_addr_data", csData, '0);

    // randomised traffic
    stallEn = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      emuLat = ($urandom_range(0, 59) == 0) ? 300 : $urandom_range(1, 8);
      if ($urandom_range(0, 199) == 0) bootBusy = !bootBusy;
      if (obsDone[0]) begin
        if ($urandom_range(0, 1) == 0) m0Req = 0; else newM0();
      end else if (!m0Req && $urandom_range(0, 23) == 0) begin
        m0Req = 1; newM0();
      end
      if (obsDone[1]) begin
        if ($urandom_range(0, 1) == 0) m1Req = 0; else newM1();
      end else if (!m1Req && $urandom_range(0, 3) == 0) begin
        m1Req = 1; newM1();
      end
      if (obsDone[2]) begin
        if ($urandom_range(0, 1) == 0) m2Req = 0; else m2Addr = AW'($urandom());
      end else if (!m2Req && $urandom_range(0, 3) == 0) begin
        m2Req = 1; m2Addr = AW'($urandom());
      end
    end

    // drain
    m0Req = 0; m1Req = 0; m2Req = 0; bootBusy = 0; stallEn = 0;
    n = 0;
    while (mBusy && n < 700) begin
      tick();
      n++;
    end
    tick();
    chk("drained", mBusy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
